// File: rtl/mux2_stream_arbiter.sv
// Two-channel round-robin stream arbiter with burst locking, beat limit and a registered output stage.
// Latency: one cycle of arbitration in IDLE, then one register stage from accepted input beat to o_vy.
// Backpressure: owner's ready is (!o_vy || i_ry); the non-owner and IDLE never see ready.
module mux2_stream_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_d0,
    input  logic             i_v0,
    input  logic             i_l0,
    output logic             o_r0,
    input  logic [WIDTH-1:0] i_d1,
    input  logic             i_v1,
    input  logic             i_l1,
    output logic             o_r1,
    output logic [WIDTH-1:0] o_y,
    output logic             o_vy,
    output logic             o_ly,
    input  logic             i_ry,
    output logic             o_sel,
    output logic             o_busy
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN0 = 2'd1,
        S_OWN1 = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_pri;
    logic               r_sel;
    logic               r_busy;
    logic [WIDTH-1:0]   r_y;
    logic               r_vy;
    logic               r_ly;
    logic [CNT_W-1:0]   r_cnt;

    logic               w_r0;
    logic               w_r1;
    logic               w_acc;
    logic               w_rel;
    logic [WIDTH-1:0]   w_dat;
    logic               w_dat_l;
    logic [CNT_W-1:0]   w_cnt_inc;
    logic               w_grant;

    // CNT_W is sized so that MAX_BURST fits; count+1 never wraps before the compare.
    assign w_cnt_inc = r_cnt + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        w_r0        = 1'b0;
        w_r1        = 1'b0;
        w_acc       = 1'b0;
        w_rel       = 1'b0;
        w_dat       = i_d0;
        w_dat_l     = i_l0;
        case (r_state)
            S_IDLE: begin
                if (i_v0 && i_v1)
                    w_state_nxt = r_pri ? S_OWN1 : S_OWN0;
                else if (i_v0)
                    w_state_nxt = S_OWN0;
                else if (i_v1)
                    w_state_nxt = S_OWN1;
            end
            S_OWN0: begin
                w_r0  = !r_vy || i_ry;
                w_acc = i_v0 && w_r0;
            end
            S_OWN1: begin
                w_r1    = !r_vy || i_ry;
                w_acc   = i_v1 && w_r1;
                w_dat   = i_d1;
                w_dat_l = i_l1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
        // A forced release at the beat limit leaves Ly alone; the burst resumes after re-arbitration.
        w_rel = w_acc && (w_dat_l || (w_cnt_inc == CNT_W'(MAX_BURST)));
        if (w_rel)
            w_state_nxt = S_IDLE;
    end

    assign w_grant = (r_state == S_IDLE) && (w_state_nxt != S_IDLE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_pri   <= 1'b0;
            r_sel   <= 1'b0;
            r_busy  <= 1'b0;
            r_y     <= '0;
            r_vy    <= 1'b0;
            r_ly    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_sel  <= (w_state_nxt == S_OWN1);
                r_busy <= 1'b1;
                r_cnt  <= '0;
            end
            if (w_acc) begin
                r_y   <= w_dat;
                r_ly  <= w_dat_l;
                r_vy  <= 1'b1;
                r_cnt <= w_cnt_inc;
            end else if (r_vy && i_ry) begin
                r_vy <= 1'b0;
            end
            if (w_rel) begin
                r_pri  <= (r_state == S_OWN0);
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end
        end
    end

    assign o_r0   = w_r0;
    assign o_r1   = w_r1;
    assign o_y    = r_y;
    assign o_vy   = r_vy;
    assign o_ly   = r_ly;
    assign o_sel  = r_sel;
    assign o_busy = r_busy;

endmodule

// File: doc/mux2_stream_arbiter.md
Name: mux2_stream_arbiter

Overview:
- Two-channel round-robin stream arbiter with burst locking and a registered output stage.
- Decides which of two valid/ready sources owns the shared path and drives the select of the downstream 2:1 data mux (Sel).
- Forwards the granted source's data through one output register.
- Guarantees fairness between bursts and bounds burst length with a beat counter.

Parameters:
- WIDTH, 8, data width of D0, D1, Y.
- MAX_BURST, 16, maximum beats per grant before forced re-arbitration (>=1).
- CNT_W, 5, beat counter width; must satisfy 2^CNT_W > MAX_BURST.

Ports:
- Clk  input  1  single clock, rising edge.
- Rst_n  input  1  asynchronous active-low reset.
- D0  input  WIDTH  channel 0 data.
- V0  input  1  channel 0 valid.
- L0  input  1  channel 0 last beat of burst.
- R0  output  1  channel 0 ready.
- D1  input  WIDTH  channel 1 data.
- V1  input  1  channel 1 valid.
- L1  input  1  channel 1 last beat of burst.
- R1  output  1  channel 1 ready.
- Y  output  WIDTH  registered output data.
- Vy  output  1  output valid.
- Ly  output  1  output last.
- Ry  input  1  downstream ready.
- Sel  output  1  current/last owner; drives downstream mux select (0 = D0, 1 = D1).
- Busy  output  1  high while a channel owns the path.

Behaviour:
- Reset (async assert, sync deassert by Clk): state IDLE, Pri=0, Sel=0, Busy=0, Y=0, Vy=0, Ly=0, beat count=0, R0=R1=0. Reset mid-burst drops the in-flight beat; no partial state survives.
- Handshake: a beat transfers on a rising edge when Vn&&Rn (input) or Vy&&Ry (output). Sources hold Vn, Dn, Ln stable until accepted. Vn may assert without waiting for Rn.
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - R0=R1=0.
  - V0&&V1: go to OWN(Pri).
  - Only Vn: go to OWNn.
  - Neither: stay in IDLE.
  - On entry to OWNn: Sel<=n, Busy<=1, count<=0. Decision is registered: one cycle.
- OWNn:
  - Rn=(!Vy||Ry); the other channel's ready=0.
  - Accept (Vn&&Rn): Y<=Dn, Ly<=Ln, Vy<=1, count<=count+1.
  - Release when the accepted beat has Ln=1, or count+1==MAX_BURST: go to IDLE, Pri<=~n, Busy<=0, count<=0. Sel holds n.
  - Forced release (MAX_BURST) does not alter Ly; the burst resumes after re-arbitration.
- Output register: if Vy&&Ry and no new accept, Vy<=0 (Y, Ly hold). Accept and output drain in the same cycle is allowed; full throughput of 1 beat/cycle in OWN state.
- Latency: Vn rising in IDLE -> Rn high next cycle -> Vy high the cycle after the first accept. Minimum 2 cycles from Vn to Vy.
- Between bursts there is one IDLE cycle of no input acceptance. The output register may still drain during it.
- Ry low with Vy high: Rn=0, output holds Y/Ly/Vy. The beat counter does not advance.
- Owner's Vn drops mid-burst (protocol gap): remain in OWNn, no acceptance. The other channel waits.
- Pri only changes on release, so a lone requester may win repeatedly.
- count never exceeds MAX_BURST-1 when registered.

Test Plan:
- Reset, then V0=1, D0=0xA5, L0=1, Ry=1: cycle1 IDLE->OWN0, R0=1; cycle2 accept; cycle3 Y=0xA5, Vy=1, Ly=1, Sel=0. Pri becomes 1.
- V0=V1=1 continuously, 2-beat bursts on each (D0=0x10,0x11; D1=0x20,0x21), Ry=1: output order 0x10,0x11,0x20,0x21,0x10,… with Sel toggling per burst.
- MAX_BURST=4, V1 held with L1=0 for 10 beats, V0=1: after 4 ch1 beats, release to ch0. Ly stays 0 on the 4th beat.
- In OWN0 with Vy=1, Ry=0 for 3 cycles: R0=0, Y stable, count unchanged. Ry=1 resumes at 1 beat/cycle.
- Assert Rst_n=0 asynchronously mid-burst (between edges): Vy, Busy, Sel, R0, R1 go to 0 immediately. After release, the FSM starts in IDLE with Pri=0.
- Both channels idle for 5 cycles after a burst: Busy=0, Sel holds last owner, Vy=0 once drained.
